// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase codes,
// direction constants and the per-head lamp bundle.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_RED   = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_EW_G  = 3'd3,
    ST_EW_Y  = 3'd4,
    ST_WALK  = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  function automatic state_e green_of(input logic dir);
    return (dir == DIR_EW) ? ST_EW_G : ST_NS_G;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase elapsed counter: clears on phase change, saturates,
// and flags when the selected duration has elapsed.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt >= dur-1 without underflow when dur is 0
  assign cnt  = cnt_q;
  assign done = cnt_inc >= {1'b0, dur};

endmodule

// File: rtl/intersection_controller.sv
// Two-head intersection sequencer with a shared pedestrian crossing.
// Optional night flash mode is enabled by defining NIGHT_MODE_EN.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_GREEN     = 50,
  parameter int T_MIN_GREEN = 10,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 20,
  parameter int T_FLASH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
`ifdef NIGHT_MODE_EN
  input  logic       night,
`endif
  output logic       ns_r,
  output logic       ns_y,
  output logic       ns_g,
  output logic       ew_r,
  output logic       ew_y,
  output logic       ew_g,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(T_MIN_GREEN - 1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             ped_pend_q, ped_pend_d;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             min_ok;
  logic             night_cut;
  logic             ped_block;
  logic             enter_walk;
  logic             ns_exit, ew_exit;
  lamp_t            ns_l, ew_l;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .dur   (dur),
    .cnt   (cnt),
    .done  (done)
  );

  always_comb begin
    unique case (state_q)
      ST_NS_G, ST_EW_G: dur = CNT_W'(T_GREEN);
      ST_NS_Y, ST_EW_Y: dur = CNT_W'(T_YELLOW);
      ST_RED:           dur = CNT_W'(T_ALLRED);
      ST_WALK:          dur = CNT_W'(T_WALK);
      default:          dur = CNT_W'(T_FLASH);
    endcase
  end

  assign min_ok = cnt >= MIN_M1;

`ifdef NIGHT_MODE_EN
  assign night_cut = night & min_ok;
  assign ped_block = (state_q == ST_FLASH) || (state_d == ST_FLASH);
`else
  assign night_cut = 1'b0;
  assign ped_block = 1'b0;
`endif

  assign ns_exit = (done & (ew_car | ped_pend_q))
                 | (min_ok & ped_pend_q) | night_cut;
  assign ew_exit = (done & (ns_car | ped_pend_q))
                 | (min_ok & ped_pend_q) | night_cut;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ST_NS_G: if (ns_exit) state_d = ST_NS_Y;
      ST_EW_G: if (ew_exit) state_d = ST_EW_Y;
      ST_NS_Y: begin
        if (done) begin
          state_d = ST_RED;
          dir_d   = DIR_EW;
        end
      end
      ST_EW_Y: begin
        if (done) begin
          state_d = ST_RED;
          dir_d   = DIR_NS;
        end
      end
      ST_RED: begin
        if (done) begin
`ifdef NIGHT_MODE_EN
          if (night)           state_d = ST_FLASH;
          else if (ped_pend_q) state_d = ST_WALK;
          else                 state_d = green_of(dir_q);
`else
          if (ped_pend_q) state_d = ST_WALK;
          else            state_d = green_of(dir_q);
`endif
        end
      end
      ST_WALK: if (done) state_d = green_of(dir_q);
`ifdef NIGHT_MODE_EN
      ST_FLASH: begin
        if (!night) begin
          state_d = ST_RED;
          dir_d   = DIR_NS;
        end
      end
`endif
      default: state_d = ST_RED;
    endcase
  end

  // a request present on the cycle WALK starts is served by that WALK
  assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);
  assign ped_ack    = ped_req & ~ped_pend_q & ~enter_walk & ~ped_block;
  assign ped_pend_d = (enter_walk | ped_block) ? 1'b0
                    : (ped_pend_q | ped_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RED;
      dir_q      <= DIR_NS;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      ped_pend_q <= ped_pend_d;
    end
  end

`ifdef NIGHT_MODE_EN
  logic [CNT_W-1:0] fc_q, fc_d;
  logic             flash_on_q, flash_on_d;

  // own half-period counter: the phase counter saturates in long FLASH
  always_comb begin
    fc_d       = '0;
    flash_on_d = 1'b1;
    if (state_q == ST_FLASH) begin
      if (fc_q == CNT_W'(T_FLASH - 1)) begin
        fc_d       = '0;
        flash_on_d = ~flash_on_q;
      end else begin
        fc_d       = fc_q + 1'b1;
        flash_on_d = flash_on_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q       <= '0;
      flash_on_q <= 1'b1;
    end else begin
      fc_q       <= fc_d;
      flash_on_q <= flash_on_d;
    end
  end
`endif

  always_comb begin
    ns_l = '{r: 1'b1, y: 1'b0, g: 1'b0};
    ew_l = '{r: 1'b1, y: 1'b0, g: 1'b0};
    case (state_q)
      ST_NS_G: ns_l = '{r: 1'b0, y: 1'b0, g: 1'b1};
      ST_NS_Y: ns_l = '{r: 1'b0, y: 1'b1, g: 1'b0};
      ST_EW_G: ew_l = '{r: 1'b0, y: 1'b0, g: 1'b1};
      ST_EW_Y: ew_l = '{r: 1'b0, y: 1'b1, g: 1'b0};
`ifdef NIGHT_MODE_EN
      ST_FLASH: begin
        ns_l = '{r: 1'b0, y: flash_on_q, g: 1'b0};
        ew_l = '{r: 1'b0, y: flash_on_q, g: 1'b0};
      end
`endif
      default: ;
    endcase
  end

  assign ns_r  = ns_l.r;
  assign ns_y  = ns_l.y;
  assign ns_g  = ns_l.g;
  assign ew_r  = ew_l.r;
  assign ew_y  = ew_l.y;
  assign ew_g  = ew_l.g;
  assign walk  = (state_q == ST_WALK);
  assign phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller; the night scenario
// runs only when NIGHT_MODE_EN is defined.
module tb_intersection_controller;

  localparam logic [2:0] P_RED   = 3'd0;
  localparam logic [2:0] P_NS_G  = 3'd1;
  localparam logic [2:0] P_NS_Y  = 3'd2;
  localparam logic [2:0] P_EW_G  = 3'd3;
  localparam logic [2:0] P_EW_Y  = 3'd4;
  localparam logic [2:0] P_WALK  = 3'd5;
  localparam logic [2:0] P_FLASH = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
`ifdef NIGHT_MODE_EN
  logic       night = 1'b0;
`endif
  logic       ns_r, ns_y, ns_g;
  logic       ew_r, ew_y, ew_g;
  logic       walk, ped_ack;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  intersection_controller dut (
    .clk     (clk),
    .reset   (reset),
    .ns_car  (ns_car),
    .ew_car  (ew_car),
    .ped_req (ped_req),
`ifdef NIGHT_MODE_EN
    .night   (night),
`endif
    .ns_r    (ns_r),
    .ns_y    (ns_y),
    .ns_g    (ns_g),
    .ew_r    (ew_r),
    .ew_y    (ew_y),
    .ew_g    (ew_g),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cycles spent in phase ph from now, bounded by limit
  task automatic measure(input logic [2:0] ph, input int limit,
                         output int n);
    n = 0;
    while (phase === ph && n < limit) begin
      n++;
      step();
    end
  endtask

  task automatic restart();
    reset   = 1'b0;
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    ped_req = 1'b0;
`ifdef NIGHT_MODE_EN
    night   = 1'b0;
`endif
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    #1;
    tests++;
    if ({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack} !== 8'b1001_0000) begin
      fails++;
      $display("FAIL reset_lamps got %b want 10010000",
               {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack});
    end
    tests++;
    if (phase !== P_RED) begin
      fails++;
      $display("FAIL reset_phase got %0d want %0d", phase, P_RED);
    end
    restart();
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL reset_red_len got %0d want 2", n);
    end
    tests++;
    if (phase !== P_NS_G || ns_g !== 1'b1 || ew_r !== 1'b1) begin
      fails++;
      $display("FAIL rest_ns_g got ph=%0d ns_g=%b ew_r=%b want ph=1 1 1",
               phase, ns_g, ew_r);
    end
    repeat (200) step();
    tests++;
    if (phase !== P_NS_G || ns_g !== 1'b1) begin
      fails++;
      $display("FAIL rest_hold got ph=%0d want 1", phase);
    end
  endtask

  task automatic test_ew_demand();
    int n;
    restart();
    ew_car = 1'b1;
    measure(P_RED, 20, n);
    measure(P_NS_G, 300, n);
    tests++;
    if (n !== 50) begin
      fails++;
      $display("FAIL ew_ns_g_len got %0d want 50", n);
    end
    tests++;
    if (ns_y !== 1'b1 || ew_r !== 1'b1 || ns_r !== 1'b0) begin
      fails++;
      $display("FAIL ew_ns_y_lamps got y=%b ew_r=%b ns_r=%b want 1 1 0",
               ns_y, ew_r, ns_r);
    end
    measure(P_NS_Y, 20, n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL ew_ns_y_len got %0d want 5", n);
    end
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL ew_red_len got %0d want 2", n);
    end
    tests++;
    if (phase !== P_EW_G || ew_g !== 1'b1 || ns_r !== 1'b1) begin
      fails++;
      $display("FAIL ew_green got ph=%0d ew_g=%b ns_r=%b want 3 1 1",
               phase, ew_g, ns_r);
    end
  endtask

  task automatic test_ped_cut();
    int n;
    restart();
    measure(P_RED, 20, n);
    repeat (3) step();
    ped_req = 1'b1;
    #1;
    tests++;
    if (ped_ack !== 1'b1) begin
      fails++;
      $display("FAIL ped_ack_first got %b want 1", ped_ack);
    end
    step();
    tests++;
    if (ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL ped_ack_once got %b want 0", ped_ack);
    end
    ped_req = 1'b0;
    measure(P_NS_G, 300, n);
    tests++;
    if (n !== 6) begin
      fails++;
      $display("FAIL ped_ns_g_rest got %0d want 6", n);
    end
    measure(P_NS_Y, 20, n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL ped_ns_y_len got %0d want 5", n);
    end
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL ped_red_len got %0d want 2", n);
    end
    tests++;
    if (walk !== 1'b1 || ns_r !== 1'b1 || ew_r !== 1'b1) begin
      fails++;
      $display("FAIL ped_walk_lamps got walk=%b ns_r=%b ew_r=%b want 1 1 1",
               walk, ns_r, ew_r);
    end
    measure(P_WALK, 50, n);
    tests++;
    if (n !== 20) begin
      fails++;
      $display("FAIL ped_walk_len got %0d want 20", n);
    end
    tests++;
    if (phase !== P_EW_G || walk !== 1'b0) begin
      fails++;
      $display("FAIL ped_after_walk got ph=%0d walk=%b want 3 0", phase, walk);
    end
  endtask

  task automatic test_ped_hold();
    int n;
    restart();
    ped_req = 1'b1;
    #1;
    tests++;
    if (ped_ack !== 1'b1) begin
      fails++;
      $display("FAIL hold_ack got %b want 1", ped_ack);
    end
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2 || phase !== P_WALK) begin
      fails++;
      $display("FAIL hold_red_to_walk got n=%0d ph=%0d want 2 5", n, phase);
    end
    ped_req = 1'b0;
    ew_car  = 1'b1;
    measure(P_WALK, 50, n);
    tests++;
    if (n !== 20 || phase !== P_NS_G) begin
      fails++;
      $display("FAIL hold_walk got n=%0d ph=%0d want 20 1", n, phase);
    end
    measure(P_NS_G, 300, n);
    tests++;
    if (n !== 50) begin
      fails++;
      $display("FAIL hold_no_pend got %0d want 50", n);
    end
    measure(P_NS_Y, 20, n);
    measure(P_RED, 20, n);
    tests++;
    if (phase !== P_EW_G) begin
      fails++;
      $display("FAIL hold_no_second_walk got ph=%0d want 3", phase);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    restart();
    ew_car = 1'b1;
    measure(P_RED, 20, n);
    measure(P_NS_G, 300, n);
    step();
    step();
    tests++;
    if (phase !== P_NS_Y) begin
      fails++;
      $display("FAIL midrst_pre got ph=%0d want 2", phase);
    end
    reset  = 1'b0;
    ew_car = 1'b0;
    #1;
    tests++;
    if ({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} !== 7'b1001000
        || phase !== P_RED) begin
      fails++;
      $display("FAIL midrst_lamps got %b ph=%0d want 1001000 0",
               {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}, phase);
    end
    step();
    reset = 1'b1;
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2 || phase !== P_NS_G) begin
      fails++;
      $display("FAIL midrst_restart got n=%0d ph=%0d want 2 1", n, phase);
    end
  endtask

`ifdef NIGHT_MODE_EN
  task automatic test_night();
    int n;
    logic exp_y;
    restart();
    ew_car = 1'b1;
    measure(P_RED, 20, n);
    measure(P_NS_G, 300, n);
    measure(P_NS_Y, 20, n);
    measure(P_RED, 20, n);
    ns_car = 1'b1;
    night  = 1'b1;
    measure(P_EW_G, 300, n);
    tests++;
    if (n !== 10 || phase !== P_EW_Y) begin
      fails++;
      $display("FAIL night_ew_g got n=%0d ph=%0d want 10 4", n, phase);
    end
    measure(P_EW_Y, 20, n);
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2 || phase !== P_FLASH) begin
      fails++;
      $display("FAIL night_to_flash got n=%0d ph=%0d want 2 6", n, phase);
    end
    ped_req = 1'b1;
    #1;
    tests++;
    if (ped_ack !== 1'b0 || ns_r !== 1'b0 || ew_r !== 1'b0 || walk !== 1'b0) begin
      fails++;
      $display("FAIL flash_quiet got ack=%b ns_r=%b ew_r=%b walk=%b want 0 0 0 0",
               ped_ack, ns_r, ew_r, walk);
    end
    ped_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_y = ((k / 4) % 2) == 0;
      tests++;
      if (ns_y !== exp_y || ew_y !== exp_y) begin
        fails++;
        $display("FAIL flash_y k=%0d got %b/%b want %b", k, ns_y, ew_y, exp_y);
      end
      step();
    end
    night  = 1'b0;
    ns_car = 1'b0;
    ew_car = 1'b0;
    step();
    measure(P_RED, 20, n);
    tests++;
    if (n !== 2 || phase !== P_NS_G) begin
      fails++;
      $display("FAIL night_exit got n=%0d ph=%0d want 2 1", n, phase);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ew_demand();
    test_ped_cut();
    test_ped_hold();
    test_mid_reset();
`ifdef NIGHT_MODE_EN
    test_night();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
